// File: rtl/subpel_row_scheduler.sv
// subpel_row_scheduler
//   Fetches NUM_ROWS reference rows for one 8x8 sub-pel block from row memory.
//   Rows are buffered in a small in-order FIFO and handed to the interpolation
//   datapath with a valid/ready handshake and a row index. The block then waits
//   for the datapath completion pulse and reports done.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, base_addr  block start (sampled in IDLE) and first row address
//   busy, done, err   status: busy while working, done pulse, sticky spurious-read flag
//   mem_*             row memory req/gnt/rvalid interface (in-order responses)
//   dp_*              datapath row stream (valid/ready, index, last) and done pulse
module subpel_row_scheduler #(
  parameter int PIX_W      = 8,
  parameter int ROW_PIX    = 15,
  parameter int NUM_ROWS   = 15,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [PIX_W*ROW_PIX-1:0] mem_rdata,
  output logic [PIX_W*ROW_PIX-1:0] dp_row,
  output logic                     dp_valid,
  input  logic                     dp_ready,
  output logic [3:0]               dp_row_idx,
  output logic                     dp_last,
  input  logic                     dp_done
);
  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT_DP, S_DONE} state_t;
  state_t r_state, w_nxt;

  logic [ADDR_W-1:0]                r_base;
  logic [CNT_W-1:0]                 r_issued, r_acc;
  logic [OCC_W-1:0]                 r_outst, r_cnt;
  logic [PTR_W-1:0]                 r_wp, r_rp;
  logic [FIFO_DEPTH-1:0][ROW_W-1:0] r_fifo;
  logic                             r_err;

  logic             w_start_acc, w_push, w_spur, w_pop, w_gnt;
  logic [OCC_W:0]   w_used;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_push      = mem_rvalid && (r_outst != '0);
  assign w_spur      = mem_rvalid && (r_outst == '0);
  assign dp_valid    = (r_cnt != '0);
  assign w_pop       = dp_valid && dp_ready;

  // Credits already committed. A row leaving the FIFO this cycle frees its slot
  // immediately, which keeps one row per cycle with a 1-cycle memory. It cannot
  // make mem_req drop before a grant: the pop is real, so next cycle the count
  // is lower still.
  assign w_used  = {1'b0, r_outst} + {1'b0, r_cnt} - {{OCC_W{1'b0}}, w_pop};
  assign mem_req = (r_state == S_FETCH) && (r_issued < CNT_W'(NUM_ROWS)) &&
                   (w_used < (OCC_W+1)'(FIFO_DEPTH));
  assign mem_addr = r_base + ADDR_W'(r_issued);   // wraps modulo 2^ADDR_W
  assign w_gnt    = mem_req && mem_gnt;

  assign dp_row     = r_fifo[r_rp];
  assign dp_row_idx = 4'(r_acc);
  assign dp_last    = dp_valid && (r_acc == CNT_W'(NUM_ROWS - 1));
  assign busy       = (r_state == S_FETCH) || (r_state == S_WAIT_DP);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_FETCH;
      S_FETCH:   if (w_pop && (r_acc == CNT_W'(NUM_ROWS - 1))) w_nxt = S_WAIT_DP;
      S_WAIT_DP: if (dp_done) w_nxt = S_DONE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base   <= '0;
      r_issued <= '0;
      r_acc    <= '0;
      r_outst  <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_fifo   <= '0;
      r_err    <= 1'b0;
    end else if (w_start_acc) begin
      r_base   <= base_addr;
      r_issued <= '0;
      r_acc    <= '0;
      r_outst  <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt) r_issued <= r_issued + 1'b1;
      case ({w_gnt, w_push})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (w_push) begin
        r_fifo[r_wp] <= mem_rdata;
        r_wp <= (r_wp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp  <= (r_rp == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
        r_acc <= r_acc + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_spur) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_subpel_row_scheduler.sv
module tb_subpel_row_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   base_addr;
  logic         busy, done, err, mem_req;
  logic [7:0]   mem_addr;
  logic         gnt_en;
  logic         mem_rvalid;
  logic [119:0] mem_rdata;
  logic [119:0] dp_row;
  logic         dp_valid, dp_ready, dp_last, dp_done;
  logic [3:0]   dp_row_idx;

  logic         mod_rv, spur_rv;
  logic [119:0] mod_rd;
  logic         g_m;
  logic [7:0]   a_m;

  assign mem_rvalid = mod_rv | spur_rv;
  assign mem_rdata  = mod_rd;

  subpel_row_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(gnt_en),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dp_row(dp_row), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_row_idx(dp_row_idx), .dp_last(dp_last), .dp_done(dp_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_grant = 0, n_pop = 0, n_done = 0, cyc_n = 0;
  int t_first = 0, t_last = 0;
  logic [7:0]   q_addr[$];
  logic [119:0] q_row[$];
  logic [3:0]   q_idx[$];
  logic [119:0] er;
  logic [3:0]   ei;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] mkrow(input logic [7:0] a);
    logic [119:0] r;
    for (int i = 0; i < 15; i++) r[i*8 +: 8] = a + 8'(i * 3 + 1);
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // memory model: fixed one-cycle read latency after each grant
  initial begin
    mod_rv = 1'b0;
    mod_rd = '0;
    forever begin
      @(negedge clk);
      g_m = rst && mem_req && gnt_en;
      a_m = mem_addr;
      @(posedge clk);
      #1;
      mod_rv = g_m;
      mod_rd = g_m ? mkrow(a_m) : '0;
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (rst) begin
      if (mem_req && gnt_en) begin
        n_grant++;
        if (q_addr.size() != 0) chk("addr", mem_addr, q_addr.pop_front());
        else chk("addr_extra", 1, 0);
      end
      if (dp_valid && dp_ready) begin
        n_pop++;
        if (q_row.size() != 0) begin
          er = q_row.pop_front();
          ei = q_idx.pop_front();
          chk("row", dp_row, er);
          chk("idx", dp_row_idx, ei);
          chk("last", dp_last, ei == 4'd14);
          if (ei == 4'd0)  t_first = cyc_n;
          if (ei == 4'd14) t_last  = cyc_n;
        end else chk("row_extra", 1, 0);
      end
      if (done) n_done++;
    end
  end

  task automatic blk(input logic [7:0] b);
    for (int i = 0; i < 15; i++) begin
      q_addr.push_back(b + 8'(i));
      q_row.push_back(mkrow(b + 8'(i)));
      q_idx.push_back(4'(i));
    end
    base_addr = b;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("err_clr", err, 0);
  endtask

  task automatic finish_blk(input bit rnd);
    for (int k = 0; k < 400 && q_row.size() != 0; k++) begin
      if (rnd) dp_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    dp_ready = 1'b1;
    chk("drain", q_row.size() == 0, 1);
    chk("addr_all", q_addr.size() == 0, 1);
    chk("busy_wait", busy, 1);
    cyc(3);
    chk("no_early_done", done, 0);
    dp_done = 1'b1;
    cyc(1);
    dp_done = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_off", busy, 0);
    cyc(1);
    chk("done_end", done, 0);
  endtask

  int d0, g0, p0;

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; gnt_en = 1'b1;
    dp_ready = 1'b1; dp_done = 1'b0; spur_rv = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", dp_valid, 0);
    chk("rst_row", dp_row, 0);
    chk("rst_idx", dp_row_idx, 0);
    rst = 1'b1;
    cyc(2);

    // basic, full throughput
    d0 = n_done;
    blk(8'h10);
    finish_blk(0);
    chk("throughput", t_last - t_first, 14);
    chk("done_cnt_basic", n_done - d0, 1);

    // backpressure
    dp_ready = 1'b0;
    g0 = n_grant;
    blk(8'h20);
    cyc(10);
    chk("bp_grants", n_grant - g0, 2);
    chk("bp_req", mem_req, 0);
    chk("bp_valid", dp_valid, 1);
    chk("bp_row", dp_row, mkrow(8'h20));
    chk("bp_idx", dp_row_idx, 0);
    dp_done = 1'b1;          // ignored outside WAIT_DP
    cyc(1);
    dp_done = 1'b0;
    cyc(3);
    chk("bp_row_hold", dp_row, mkrow(8'h20));
    chk("bp_busy", busy, 1);
    finish_blk(1);

    // address wrap
    blk(8'hF8);
    finish_blk(1);

    // spurious read while idle
    spur_rv = 1'b1;
    cyc(1);
    spur_rv = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_valid", dp_valid, 0);
    cyc(1);
    chk("spur_sticky", err, 1);
    blk(8'h60);
    finish_blk(0);

    // start while busy is ignored
    d0 = n_done;
    blk(8'h30);
    cyc(3);
    base_addr = 8'h40;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    finish_blk(0);
    cyc(2);
    chk("one_done", n_done - d0, 1);

    // reset mid-fetch
    p0 = n_pop;
    blk(8'h50);
    for (int k = 0; k < 100 && n_pop < p0 + 5; k++) cyc(1);
    chk("mid_pops", n_pop - p0, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_req", mem_req, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_valid", dp_valid, 0);
    chk("mrst_row", dp_row, 0);
    chk("mrst_idx", dp_row_idx, 0);
    q_addr.delete();
    q_row.delete();
    q_idx.delete();
    cyc(2);
    rst = 1'b1;
    cyc(1);
    spur_rv = 1'b1;
    cyc(1);
    spur_rv = 1'b0;
    chk("late_rv_err", err, 1);
    blk(8'h50);
    finish_blk(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
